// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter: shares one 512x8 SRAM between a Wishbone slave (split into byte-lane
// RAM cycles) and a byte-wide client B, round-robin at transaction boundaries.
module wb_sram_arbiter #(
    parameter logic [31:0] WB_BASE = 32'h3000_0000,
    parameter logic [31:0] WB_MASK = 32'hFFFF_FE00
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        b_req_i,
    input  logic        b_we_i,
    input  logic [8:0]  b_addr_i,
    input  logic [7:0]  b_wdata_i,
    output logic        b_ack_o,
    output logic [7:0]  b_rdata_o,
    output logic        ram_cen_o,
    output logic        ram_gwen_o,
    output logic [7:0]  ram_wen_o,
    output logic [8:0]  ram_a_o,
    output logic [7:0]  ram_d_o,
    input  logic [7:0]  ram_q_i
);
    localparam logic [2:0] IDLE = 3'd0, WB_ACC = 3'd1, WB_CAP = 3'd2, B_ACC = 3'd3, B_CAP = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        last_wb_q, last_wb_d;
    logic [3:0]  rem_q, rem_d;
    logic [1:0]  lane_q, lane_d, cap_q, cap_d;
    logic        cap_vld_q, cap_vld_d, we_q, we_d;
    logic [6:0]  widx_q, widx_d;
    logic [31:0] wdat_q, wdat_d, rbuf_q, rbuf_d, dat_q, dat_d;
    logic        ack_q, ack_d, back_q, back_d;
    logic [7:0]  brd_q, brd_d;
    logic        cen_q, cen_d, gwen_q, gwen_d;
    logic [7:0]  wen_q, wen_d, d_q, d_d;
    logic [8:0]  a_q, a_d;

    logic        wb_p, b_p, wb_hit, grant_wb;
    logic [3:0]  m, rem_n;
    logic [1:0]  lane;
    logic [31:0] rbuf_c;

    // Next lane is the lowest set bit of the sel mask at grant, of the remaining mask afterwards.
    assign m        = (state_q == IDLE) ? wbs_sel_i : rem_q;
    assign lane     = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    assign rem_n    = m & (m - 4'd1);
    assign wb_p     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign b_p      = b_req_i & ~back_q;
    assign wb_hit   = ((wbs_adr_i & WB_MASK) == WB_BASE) && (wbs_sel_i != 4'h0);
    assign grant_wb = wb_p & (~b_p | ~last_wb_q);

    always_comb begin
        rbuf_c = rbuf_q;
        rbuf_c[{cap_q, 3'b000} +: 8] = ram_q_i;
    end

    always_comb begin
        state_d   = state_q;
        last_wb_d = last_wb_q;
        rem_d     = rem_q;
        lane_d    = lane_q;
        cap_d     = cap_q;
        cap_vld_d = cap_vld_q;
        we_d      = we_q;
        widx_d    = widx_q;
        wdat_d    = wdat_q;
        rbuf_d    = rbuf_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        back_d    = 1'b0;
        brd_d     = brd_q;
        cen_d     = cen_q;
        gwen_d    = gwen_q;
        wen_d     = wen_q;
        a_d       = a_q;
        d_d       = d_q;
        case (state_q)
            IDLE: begin
                if (grant_wb) begin
                    last_wb_d = 1'b1;
                    if (wb_hit) begin
                        state_d   = WB_ACC;
                        we_d      = wbs_we_i;
                        widx_d    = wbs_adr_i[8:2];
                        wdat_d    = wbs_dat_i;
                        rbuf_d    = 32'h0;
                        cap_vld_d = 1'b0;
                        lane_d    = lane;
                        rem_d     = rem_n;
                        cen_d     = 1'b0;
                        gwen_d    = ~wbs_we_i;
                        wen_d     = wbs_we_i ? 8'h00 : 8'hFF;
                        a_d       = {wbs_adr_i[8:2], lane};
                        d_d       = wbs_dat_i[{lane, 3'b000} +: 8];
                    end else begin
                        ack_d = 1'b1;
                        dat_d = 32'h0;
                    end
                end else if (b_p) begin
                    state_d   = B_ACC;
                    last_wb_d = 1'b0;
                    we_d      = b_we_i;
                    cen_d     = 1'b0;
                    gwen_d    = ~b_we_i;
                    wen_d     = b_we_i ? 8'h00 : 8'hFF;
                    a_d       = b_addr_i;
                    d_d       = b_wdata_i;
                end
            end
            WB_ACC: begin
                // q for the lane sampled on the previous edge is captured one edge later.
                rbuf_d    = cap_vld_q ? rbuf_c : rbuf_q;
                cap_d     = lane_q;
                cap_vld_d = ~we_q;
                if (rem_q != 4'h0) begin
                    lane_d = lane;
                    rem_d  = rem_n;
                    a_d    = {widx_q, lane};
                    d_d    = wdat_q[{lane, 3'b000} +: 8];
                end else begin
                    cen_d   = 1'b1;
                    gwen_d  = 1'b1;
                    wen_d   = 8'hFF;
                    ack_d   = we_q;
                    state_d = we_q ? IDLE : WB_CAP;
                end
            end
            WB_CAP: begin
                dat_d     = rbuf_c;
                ack_d     = 1'b1;
                cap_vld_d = 1'b0;
                state_d   = IDLE;
            end
            B_ACC: begin
                cen_d   = 1'b1;
                gwen_d  = 1'b1;
                wen_d   = 8'hFF;
                back_d  = we_q;
                state_d = we_q ? IDLE : B_CAP;
            end
            B_CAP: begin
                brd_d   = ram_q_i;
                back_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            last_wb_q <= 1'b0;
            rem_q     <= 4'h0;
            lane_q    <= 2'd0;
            cap_q     <= 2'd0;
            cap_vld_q <= 1'b0;
            we_q      <= 1'b0;
            widx_q    <= 7'h0;
            wdat_q    <= 32'h0;
            rbuf_q    <= 32'h0;
            dat_q     <= 32'h0;
            ack_q     <= 1'b0;
            back_q    <= 1'b0;
            brd_q     <= 8'h0;
            cen_q     <= 1'b1;
            gwen_q    <= 1'b1;
            wen_q     <= 8'hFF;
            a_q       <= 9'h0;
            d_q       <= 8'h0;
        end else begin
            state_q   <= state_d;
            last_wb_q <= last_wb_d;
            rem_q     <= rem_d;
            lane_q    <= lane_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
            we_q      <= we_d;
            widx_q    <= widx_d;
            wdat_q    <= wdat_d;
            rbuf_q    <= rbuf_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            back_q    <= back_d;
            brd_q     <= brd_d;
            cen_q     <= cen_d;
            gwen_q    <= gwen_d;
            wen_q     <= wen_d;
            a_q       <= a_d;
            d_q       <= d_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign b_ack_o    = back_q;
    assign b_rdata_o  = brd_q;
    assign ram_cen_o  = cen_q;
    assign ram_gwen_o = gwen_q;
    assign ram_wen_o  = wen_q;
    assign ram_a_o    = a_q;
    assign ram_d_o    = d_q;
endmodule

// File: tb/tb_wb_sram_arbiter.sv
// tb_wb_sram_arbiter: drives WB and B traffic into the arbiter backed by an SRAM model,
// predicting latencies, read data and RAM writes from a transaction-level memory model.
module tb_wb_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        wack;
    logic [31:0] rdat;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [8:0]  b_addr = 9'h0;
    logic [7:0]  b_wdata = 8'h0;
    logic        b_ack;
    logic [7:0]  b_rdata;
    logic        cen, gwen;
    logic [7:0]  wen, ram_d, ram_q;
    logic [8:0]  ram_a;

    always #5 clk = ~clk;

    wb_sram_arbiter dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(wack), .wbs_dat_o(rdat),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack), .b_rdata_o(b_rdata),
        .ram_cen_o(cen), .ram_gwen_o(gwen), .ram_wen_o(wen), .ram_a_o(ram_a),
        .ram_d_o(ram_d), .ram_q_i(ram_q)
    );

    // SRAM macro model with an access counter and a log of writes.
    logic [7:0]  mem [512];
    int          acc_cnt = 0;
    logic [16:0] wlog[$];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        ram_q = 8'h00;
    end
    always @(posedge clk) begin
        if (!cen) begin
            acc_cnt++;
            if (!gwen) begin
                mem[ram_a] = (mem[ram_a] & wen) | (ram_d & ~wen);
                wlog.push_back({ram_a, ram_d});
            end else begin
                ram_q <= mem[ram_a];
            end
        end
    end

    int errors = 0, checks = 0;
    logic [7:0] ref_mem [512];
    bit last_wb = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_wb(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output int nacc);
        bit hit;
        int n;
        logic [8:0] idx;
        hit  = ((a & 32'hFFFF_FE00) == 32'h3000_0000) && (s != 4'h0);
        n    = $countones(s);
        rd   = 32'h0;
        nacc = hit ? n : 0;
        lat  = !hit ? 1 : (w ? n + 1 : n + 2);
        if (hit)
            for (int k = 0; k < 4; k++)
                if (s[k]) begin
                    idx = {a[8:2], k[1:0]};
                    if (w) ref_mem[idx] = d[8*k +: 8];
                    else rd[8*k +: 8] = ref_mem[idx];
                end
    endtask

    task automatic ref_b(input bit w, input logic [8:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd);
        lat = w ? 2 : 3;
        rd  = ref_mem[a];
        if (w) ref_mem[a] = d;
    endtask

    task automatic wb_single(input bit w, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d, input string tag);
        int lat, nacc, cnt, acc0, j;
        logic [31:0] exp_rd, got;
        ref_wb(w, a, s, d, lat, exp_rd, nacc);
        last_wb = 1'b1;
        @(negedge clk);
        acc0 = acc_cnt;
        wlog.delete();
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        cnt = 0;
        got = 'x;
        while (cnt < 30) begin
            @(negedge clk);
            cnt++;
            if (wack) begin
                got = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        check({tag, " ack latency"}, cnt, lat);
        if (!w) check({tag, " read data"}, got, exp_rd);
        check({tag, " ram cycles"}, acc_cnt - acc0, nacc);
        if (w && nacc > 0) begin
            j = 0;
            for (int k = 0; k < 4; k++)
                if (s[k]) begin
                    check({tag, " ram write"}, (j < wlog.size()) ? 32'(wlog[j]) : 32'hFFFF_FFFF,
                          32'({a[8:2], k[1:0], d[8*k +: 8]}));
                    j++;
                end
        end
        @(negedge clk);
        check({tag, " ack one cycle"}, 32'(wack), 32'h0);
    endtask

    task automatic b_single(input bit w, input logic [8:0] a, input logic [7:0] d, input string tag);
        int lat, cnt;
        logic [7:0] exp_rd, got;
        ref_b(w, a, d, lat, exp_rd);
        last_wb = 1'b0;
        @(negedge clk);
        b_req = 1'b1; b_we = w; b_addr = a; b_wdata = d;
        cnt = 0;
        got = 'x;
        while (cnt < 30) begin
            @(negedge clk);
            cnt++;
            if (b_ack) begin
                got = b_rdata;
                break;
            end
        end
        b_req = 1'b0;
        check({tag, " b latency"}, cnt, lat);
        if (!w) check({tag, " b read data"}, 32'(got), 32'(exp_rd));
    endtask

    // Both ports request on the same cycle; the winner is the port opposite the last grant.
    task automatic pair(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input bit bw, input logic [8:0] ba, input logic [7:0] bd, input string tag);
        bit wb_first, wdone, bdone;
        int wlat, blat, nacc, cnt, wcnt, bcnt;
        logic [31:0] wexp, wgot;
        logic [7:0]  bexp, bgot;
        wb_first = !last_wb;
        if (wb_first) begin
            ref_wb(w, a, s, d, wlat, wexp, nacc);
            ref_b(bw, ba, bd, blat, bexp);
        end else begin
            ref_b(bw, ba, bd, blat, bexp);
            ref_wb(w, a, s, d, wlat, wexp, nacc);
        end
        last_wb = !wb_first;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        b_req = 1'b1; b_we = bw; b_addr = ba; b_wdata = bd;
        wdone = 1'b0; bdone = 1'b0; cnt = 0; wcnt = 0; bcnt = 0;
        wgot = 'x; bgot = 'x;
        while (cnt < 40 && !(wdone && bdone)) begin
            @(negedge clk);
            cnt++;
            if (wack && !wdone) begin
                wdone = 1'b1; wcnt = cnt; wgot = rdat; cyc = 1'b0; stb = 1'b0;
            end
            if (b_ack && !bdone) begin
                bdone = 1'b1; bcnt = cnt; bgot = b_rdata; b_req = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0; b_req = 1'b0;
        check({tag, " wb ack cycle"}, wcnt, wb_first ? wlat : blat + wlat);
        check({tag, " b ack cycle"}, bcnt, wb_first ? wlat + blat : blat);
        if (!w) check({tag, " wb read data"}, wgot, wexp);
        if (!bw) check({tag, " b read data"}, 32'(bgot), 32'(bexp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        // Reset held with both ports requesting.
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0000; sel = 4'hF;
        b_req = 1'b1; b_addr = 9'h3;
        repeat (3) @(negedge clk);
        check("reset cen", 32'(cen), 32'h1);
        check("reset wen", 32'(wen), 32'hFF);
        check("reset gwen", 32'(gwen), 32'h1);
        check("reset wb ack", 32'(wack), 32'h0);
        check("reset b ack", 32'(b_ack), 32'h0);
        check("reset wb dat", rdat, 32'h0);
        cyc = 1'b0; stb = 1'b0; b_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        pair(1'b0, 32'h3000_0000, 4'b0001, 32'h0, 1'b1, 9'd9, 8'h5A, "tie1");
        pair(1'b0, 32'h3000_0000, 4'b0001, 32'h0, 1'b0, 9'd9, 8'h00, "tie2");
        wb_single(1'b1, 32'h3000_0004, 4'b1010, 32'hAABB_CCDD, "wr sel1010");
        pair(1'b0, 32'h3000_0008, 4'b0001, 32'h0, 1'b1, 9'd9, 8'hA5, "tie3");
        wb_single(1'b1, 32'h3000_0004, 4'hF, 32'h4433_2211, "wr word");
        wb_single(1'b0, 32'h3000_0004, 4'hF, 32'h0, "rd word");
        wb_single(1'b0, 32'h3000_0004, 4'b0101, 32'h0, "rd sel0101");
        b_single(1'b0, 9'd6, 8'h0, "b rd");
        b_single(1'b1, 9'h1FF, 8'hC3, "b wr top");
        wb_single(1'b0, 32'h3000_01FC, 4'b1000, 32'h0, "rd top");
        wb_single(1'b0, 32'h2000_0000, 4'hF, 32'h0, "miss rd");
        wb_single(1'b1, 32'h3000_0200, 4'hF, 32'h1234_5678, "miss wr");
        wb_single(1'b0, 32'h3000_0004, 4'h0, 32'h0, "sel0");

        // Reset in the middle of a 4-lane write: lanes 0 and 1 land, the rest do not.
        @(negedge clk);
        acc0 = acc_cnt;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0010; sel = 4'hF; wdat = 32'hD4C3_B2A1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst cen", 32'(cen), 32'h1);
        check("midrst ack", 32'(wack), 32'h0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst no ack", 32'(wack), 32'h0);
        end
        check("midrst ram cycles", acc_cnt - acc0, 2);
        rst_n = 1'b1;
        ref_mem[9'h10] = 8'hA1;
        ref_mem[9'h11] = 8'hB2;
        last_wb = 1'b0;
        wb_single(1'b0, 32'h3000_0010, 4'hF, 32'h0, "midrst readback");

        for (int it = 0; it < 40; it++) begin
            logic [31:0] ra, rd;
            logic [3:0]  rs;
            bit          rw, bw;
            logic [8:0]  ba;
            logic [7:0]  bd;
            int          kind;
            ra   = ($urandom_range(0, 7) == 0) ? (32'h2000_0000 | ($urandom & 32'h1FC))
                                               : (32'h3000_0000 | ($urandom & 32'h1FC));
            rs   = 4'($urandom);
            rd   = $urandom;
            rw   = 1'($urandom);
            bw   = 1'($urandom);
            ba   = 9'($urandom);
            bd   = 8'($urandom);
            kind = $urandom_range(0, 2);
            if (kind == 0) wb_single(rw, ra, rs, rd, "rand wb");
            else if (kind == 1) b_single(bw, ba, bd, "rand b");
            else pair(rw, ra, rs, rd, bw, ba, bd, "rand pair");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
